uart_tx_stim: RTL

UART_TX_STIM -- requirements
Module: uart_tx_stim

---
 rtl/uart_pkg.sv | 15 +
 rtl/sync_fifo.sv | 48 ++++
 rtl/uart_tx_stim.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the FIFO-fed UART transmitter.
// Holds the FSM state encoding and the parity mode selectors.
package uart_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_PAR   = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign level = wr_ptr_q - rd_ptr_q;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);

    // A push while full is dropped, even when a pop happens on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_tx_stim.sv
// UART transmitter fed from a small FIFO: frames are START, DATA (LSB first),
// optional parity, then one or two STOP bits, each bit CLK_DIV sysclk cycles.
import uart_pkg::*;

module uart_tx_stim #(
    parameter int CLK_DIV    = 4,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 full,
    output logic [LW-1:0]        level,
    output logic                 overflow,
    output logic                 busy,
    output logic                 tx,
    output logic [2:0]           dbg_state_o
);

    localparam logic [15:0] BIT_RELOAD = 16'(CLK_DIV - 1);
    localparam logic [3:0]  DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic        STOP_LAST  = 1'(STOP_BITS - 1);

    logic [2:0]           state_q, state_d;
    logic [15:0]          timer_q, timer_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 overflow_q;
    logic                 load_frame;
    logic                 fifo_pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [DATA_BITS-1:0] fifo_dout;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sysclk),
        .rst_n (reset),
        .push  (wr_en),
        .pop   (fifo_pop),
        .din   (wr_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        tx_d       = tx_q;
        load_frame = 1'b0;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                tx_d    = 1'b1;
                if (!fifo_empty) load_frame = 1'b1;
            end
            ST_START: begin
                if (timer_q == '0) begin
                    state_d   = ST_DATA;
                    timer_d   = BIT_RELOAD;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_DATA: begin
                if (timer_q == '0) begin
                    timer_d = BIT_RELOAD;
                    if (bit_cnt_q != DATA_LAST) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end else if (PARITY != PARITY_NONE) begin
                        state_d = ST_PAR;
                        tx_d    = par_q;
                    end else begin
                        state_d    = ST_STOP;
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_PAR: begin
                if (timer_q == '0) begin
                    state_d    = ST_STOP;
                    timer_d    = BIT_RELOAD;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_STOP: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end else if (stop_cnt_q != STOP_LAST) begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                    timer_d    = BIT_RELOAD;
                end else if (!fifo_empty) begin
                    load_frame = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
                tx_d    = 1'b1;
            end
        endcase
        // Popping straight into START from STOP keeps back-to-back frames gapless.
        if (load_frame) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            par_d    = (PARITY == PARITY_ODD) ? ~(^fifo_dout) : ^fifo_dout;
            state_d  = ST_START;
            timer_d  = BIT_RELOAD;
            tx_d     = 1'b0;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_q | (wr_en & fifo_full);
        end
    end

    assign full        = fifo_full;
    assign overflow    = overflow_q;
    assign busy        = (state_q != ST_IDLE);
    assign tx          = tx_q;
    assign dbg_state_o = state_q;

endmodule
